multicycle_control_fsm: RTL and testbench
=========================================

// Module: multicycle_control_fsm
// PURPOSE
// - Main control FSM of the multicycle core. Sequences program_counter_multi (pc_en/bias_en/bias), latches the fetched instruction,
//   decodes the RV32I subset and drives ALU, register-file and data-memory controls with a ready handshake.
// - Sits between program_counter_multi, the regfile/ALU datapath and data memory; the only block that moves the PC.
// PARAMETERS
// - PC_W        8    width of program_counter / bias (word index)
// - MEM_TMO     15   max MEM wait cycles for mem_ready before trap (4-bit counter)
// PORTS
// - clk          in   1   rising-edge clock
// - rst_n        in   1   asynchronous active-low reset
// - instruction  in   32  instruction_output of program_counter_multi (combinational from current PC)
// - program_counter in PC_W current PC word index
// - alu_zero     in   1   ALU result == 0, valid in EXEC
// - mem_ready    in   1   data memory completed request this cycle
// - pc_en        out  1   increment PC (one pulse per instruction)
// - bias_en      out  1   load PC from bias (precedence over pc_en in PC)
// - bias         out  PC_W jump/branch target word index
// - rf_we        out  1   regfile write strobe
// - alu_src_imm  out  1   ALU operand B = imm
// - alu_op       out  4   {funct7[5],funct3} for R/I-ALU; 4'b0000 (add) for load/store/jal; 4'b1000 (sub) for branch
// - imm          out  32  sign-extended immediate of latched instruction
// - mem_req      out  1   data memory request, held until mem_ready
// - mem_we       out  1   request is a store
// - wb_sel       out  2   00 ALU, 01 load data, 10 return address (PC of instr + 1, word)
// - halted       out  1   ECALL reached; core stopped
// - trap         out  1   illegal opcode/funct3 or memory timeout; core stopped
// BEHAVIOUR
// - Reset: state=FETCH, ir=0, pc_ir=0, every output 0. Reset mid-MEM drops mem_req immediately (async) and the access is abandoned.
// - States: FETCH, DECODE, EXEC, MEM, WB, HALT, TRAP; exactly one state per cycle.
// - FETCH (1 cycle): ir<=instruction, pc_ir<=program_counter, pc_en=1 -> DECODE.
// - DECODE (1 cycle): ir opcode check; 0110011 R, 0010011 I-ALU, 0000011 LW, 0100011 SW, 1100011 BEQ/BNE, 1101111 JAL,
//   1110011 ECALL -> HALT; any other opcode, or branch funct3 not 000/001 -> TRAP. Otherwise -> EXEC.
// - EXEC (1 cycle): ALU controls valid. R/I -> WB. LW/SW -> MEM. JAL: bias_en=1 -> WB.
//   Branch: taken = (funct3==000)?alu_zero:!alu_zero; taken drives bias_en=1; -> FETCH either way.
// - bias = pc_ir + imm[PC_W+1:2], modulo 2^PC_W (wrap-around silent); imm[1:0] ignored.
// - MEM: mem_req=1, mem_we=(SW); wait for mem_ready. On ready: LW -> WB, SW -> FETCH. Timeout counter loads 0 on entry;
//   after MEM_TMO cycles without ready -> TRAP (mem_req drops next cycle).
// - WB (1 cycle): rf_we=1 unless rd==0; wb_sel per type -> FETCH.
// - HALT/TRAP: absorbing until reset; all strobes 0, halted/trap held 1.
// - Latencies (cycles incl. FETCH): R/I 4, JAL 4, branch 3, SW 4+wait, LW 5+wait.
// - imm: I/LW[31:20], SW{[31:25],[11:7]}, B{[31],[7],[30:25],[11:8],0}, J{[31],[19:12],[20],[30:21],0}; R -> 0.
// - pc_en and bias_en never both 1 in the same cycle.
// CONFIGURATION
// - MULTI_CTRL_PERF_EN defined: adds outputs cycle_cnt[31:0] (counts every non-reset cycle outside HALT/TRAP)
//   and instret_cnt[31:0] (+1 on each instruction's last state); both reset to 0, wrap at 2^32.
// - Undefined: ports and counters absent; all other behaviour identical.
// TESTING
// - Reset released, instruction=ADDI x1,x0,5 (0x00500093) -> pc_en at cycle 0, rf_we=1 wb_sel=00 imm=5 at cycle 3, back in FETCH cycle 4.
// - BEQ offset +8 at PC 3, alu_zero=1 -> bias_en=1 bias=5 in cycle 2; alu_zero=0 -> bias_en=0, only pc_en pulse.
// - JAL offset -16 at PC 2 -> bias=254 (wrap), rf_we=1 wb_sel=10 in WB.
// - LW with mem_ready after 3 cycles -> mem_req high exactly 3 cycles, then WB wb_sel=01; no ready for 15 cycles -> trap=1.
// - Opcode 0x7F or BEQ funct3=010 -> trap=1 after DECODE, no further pc_en; ECALL -> halted=1.
// - Assert rst_n low during MEM -> mem_req 0 same cycle, state FETCH and all outputs 0 after release.

Source files
------------

// File: rtl/multicycle_control_fsm.sv
// Multicycle core control FSM: sequences fetch/decode/exec/mem/wb for an RV32I subset.
// Define MULTI_CTRL_PERF_EN to add the cycle_cnt / instret_cnt performance counters.
module multicycle_control_fsm #(
    parameter int PC_W    = 8,
    parameter int MEM_TMO = 15
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [31:0]     instruction,
    input  logic [PC_W-1:0] program_counter,
    input  logic            alu_zero,
    input  logic            mem_ready,
    output logic            pc_en,
    output logic            bias_en,
    output logic [PC_W-1:0] bias,
    output logic            rf_we,
    output logic            alu_src_imm,
    output logic [3:0]      alu_op,
    output logic [31:0]     imm,
    output logic            mem_req,
    output logic            mem_we,
    output logic [1:0]      wb_sel,
    output logic            halted,
    output logic            trap
`ifdef MULTI_CTRL_PERF_EN
    ,
    output logic [31:0]     cycle_cnt,
    output logic [31:0]     instret_cnt
`endif
);

    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_BR  = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;
    localparam logic [6:0] OP_SYS = 7'b1110011;

    typedef enum logic [2:0] {
        S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT, S_TRAP
    } state_e;

    state_e          r_state;
    state_e          w_next;
    logic [31:0]     r_ir;
    logic [PC_W-1:0] r_pc_ir;
    logic [3:0]      r_tmo;

    logic [2:0]      w_f3;
    logic            w_is_r, w_is_i, w_is_lw, w_is_sw;
    logic            w_is_br, w_is_jal, w_is_ecall;
    logic            w_legal, w_taken, w_tmo_hit;
    logic [31:0]     w_imm;
    logic [PC_W-1:0] w_bias;

    assign w_f3       = r_ir[14:12];
    assign w_is_r     = (r_ir[6:0] == OP_R);
    assign w_is_i     = (r_ir[6:0] == OP_I);
    assign w_is_lw    = (r_ir[6:0] == OP_LW);
    assign w_is_sw    = (r_ir[6:0] == OP_SW);
    assign w_is_br    = (r_ir[6:0] == OP_BR);
    assign w_is_jal   = (r_ir[6:0] == OP_JAL);
    assign w_is_ecall = (r_ir[6:0] == OP_SYS);
    assign w_legal    = w_is_r | w_is_i | w_is_lw | w_is_sw | w_is_jal
                      | (w_is_br & (w_f3[2:1] == 2'b00));
    assign w_taken    = w_f3[0] ? !alu_zero : alu_zero;
    assign w_tmo_hit  = (r_tmo == 4'(MEM_TMO - 1));

    always_comb begin
        w_imm = '0;
        unique case (1'b1)
            w_is_i, w_is_lw: w_imm = {{20{r_ir[31]}}, r_ir[31:20]};
            w_is_sw:  w_imm = {{20{r_ir[31]}}, r_ir[31:25], r_ir[11:7]};
            w_is_br:  w_imm = {{19{r_ir[31]}}, r_ir[31], r_ir[7],
                               r_ir[30:25], r_ir[11:8], 1'b0};
            w_is_jal: w_imm = {{11{r_ir[31]}}, r_ir[31], r_ir[19:12],
                               r_ir[20], r_ir[30:21], 1'b0};
            default:  w_imm = '0;
        endcase
    end

    // Targets are word indices, so the byte offset drops its low two bits.
    assign w_bias = r_pc_ir + w_imm[PC_W+1:2];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_FETCH;
            r_ir    <= '0;
            r_pc_ir <= '0;
            r_tmo   <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == S_FETCH) begin
                r_ir    <= instruction;
                r_pc_ir <= program_counter;
            end
            if (r_state == S_MEM) r_tmo <= r_tmo + 4'd1;
            else                  r_tmo <= '0;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_FETCH:  w_next = S_DECODE;
            S_DECODE: begin
                if (w_is_ecall)    w_next = S_HALT;
                else if (!w_legal) w_next = S_TRAP;
                else               w_next = S_EXEC;
            end
            S_EXEC: begin
                if (w_is_br)                w_next = S_FETCH;
                else if (w_is_lw | w_is_sw) w_next = S_MEM;
                else                        w_next = S_WB;
            end
            S_MEM: begin
                if (mem_ready)      w_next = w_is_lw ? S_WB : S_FETCH;
                else if (w_tmo_hit) w_next = S_TRAP;
            end
            S_WB:    w_next = S_FETCH;
            S_HALT:  w_next = S_HALT;
            S_TRAP:  w_next = S_TRAP;
            default: w_next = S_FETCH;
        endcase
    end

    always_comb begin
        pc_en       = 1'b0;
        bias_en     = 1'b0;
        rf_we       = 1'b0;
        mem_req     = 1'b0;
        mem_we      = 1'b0;
        wb_sel      = 2'b00;
        halted      = 1'b0;
        trap        = 1'b0;
        bias        = w_bias;
        imm         = w_imm;
        alu_src_imm = w_is_i | w_is_lw | w_is_sw;
        alu_op      = 4'b0000;
        if (w_is_r | w_is_i) alu_op = {r_ir[30], w_f3};
        else if (w_is_br)    alu_op = 4'b1000;
        unique case (r_state)
            // Held low while reset is asserted so the PC cannot step.
            S_FETCH: pc_en = rst_n;
            S_EXEC:  bias_en = w_is_jal | (w_is_br & w_taken);
            S_MEM: begin
                mem_req = 1'b1;
                mem_we  = w_is_sw;
            end
            S_WB: begin
                rf_we = (r_ir[11:7] != 5'd0);
                if (w_is_lw)       wb_sel = 2'b01;
                else if (w_is_jal) wb_sel = 2'b10;
            end
            S_HALT:  halted = 1'b1;
            S_TRAP:  trap = 1'b1;
            default: ;
        endcase
    end

`ifdef MULTI_CTRL_PERF_EN
    logic [31:0] r_cycle_cnt;
    logic [31:0] r_instret_cnt;
    logic        w_retire;

    assign w_retire = (r_state == S_WB)
                    | (r_state == S_EXEC && w_is_br)
                    | (r_state == S_MEM && mem_ready && w_is_sw)
                    | (r_state == S_DECODE && w_is_ecall);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cycle_cnt   <= '0;
            r_instret_cnt <= '0;
        end else begin
            if (r_state != S_HALT && r_state != S_TRAP)
                r_cycle_cnt <= r_cycle_cnt + 32'd1;
            if (w_retire)
                r_instret_cnt <= r_instret_cnt + 32'd1;
        end
    end

    assign cycle_cnt   = r_cycle_cnt;
    assign instret_cnt = r_instret_cnt;
`endif

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Bench for multicycle_control_fsm: instruction-level reference model,
// directed scenarios and random programs.
module tb_multicycle_control_fsm;

    localparam int K_R = 0, K_I = 1, K_LW = 2, K_SW = 3;
    localparam int K_BR = 4, K_JAL = 5, K_EC = 6, K_ILL = 7;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] instruction;
    logic [7:0]  program_counter = 8'd0;
    logic        alu_zero = 1'b0;
    logic        mem_ready = 1'b0;
    logic        pc_en, bias_en, rf_we, alu_src_imm;
    logic [7:0]  bias;
    logic [3:0]  alu_op;
    logic [31:0] imm;
    logic        mem_req, mem_we, halted, trap;
    logic [1:0]  wb_sel;

    logic [31:0] prog [0:255];
    assign instruction = prog[program_counter];

    always #5 clk = ~clk;

    multicycle_control_fsm #(.PC_W(8), .MEM_TMO(15)) dut (
        .clk(clk), .rst_n(rst_n), .instruction(instruction),
        .program_counter(program_counter), .alu_zero(alu_zero),
        .mem_ready(mem_ready), .pc_en(pc_en), .bias_en(bias_en),
        .bias(bias), .rf_we(rf_we), .alu_src_imm(alu_src_imm),
        .alu_op(alu_op), .imm(imm), .mem_req(mem_req), .mem_we(mem_we),
        .wb_sel(wb_sel), .halted(halted), .trap(trap)
    );

    int checks = 0;
    int errors = 0;

    // Instruction-level model: cycle index within the instruction.
    int          m_k, m_wait, m_target, m_stop;
    bit          m_inmem;
    logic [31:0] m_ir;
    logic [7:0]  m_pc, m_pcir;
    int          scen, zmode, tgt_fixed, cyc, mcount;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s t=%0t actual=%0h required=%0h",
                     nm, $time, act, exp);
        end
    endtask

    function automatic int kind_of(input logic [31:0] x);
        case (x[6:0])
            7'b0110011: return K_R;
            7'b0010011: return K_I;
            7'b0000011: return K_LW;
            7'b0100011: return K_SW;
            7'b1100011: return (x[14:13] == 2'b00) ? K_BR : K_ILL;
            7'b1101111: return K_JAL;
            7'b1110011: return K_EC;
            default:    return K_ILL;
        endcase
    endfunction

    function automatic logic [31:0] imm_of(input logic [31:0] x);
        case (x[6:0])
            7'b0010011, 7'b0000011:
                return {{20{x[31]}}, x[31:20]};
            7'b0100011:
                return {{20{x[31]}}, x[31:25], x[11:7]};
            7'b1100011:
                return {{19{x[31]}}, x[31], x[7], x[30:25], x[11:8], 1'b0};
            7'b1101111:
                return {{11{x[31]}}, x[31], x[19:12], x[20], x[30:21], 1'b0};
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic [7:0] tgt_of(input logic [7:0] pc,
                                          input logic [31:0] x);
        int off;
        off = $signed(imm_of(x)) >>> 2;
        return 8'(int'(pc) + off);
    endfunction

    function automatic logic [3:0] aluop_of(input logic [31:0] x);
        int k;
        k = kind_of(x);
        if (k == K_R || k == K_I) return {x[30], x[14:12]};
        if (k == K_BR) return 4'b1000;
        return 4'b0000;
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [31:0] x;
        int r;
        x = $urandom;
        r = $urandom_range(0, 99);
        if (r < 20) begin
            x[31] = 1'b0; x[29:25] = 5'd0; x[6:0] = 7'b0110011;
        end else if (r < 40) begin
            x[6:0] = 7'b0010011;
        end else if (r < 52) begin
            x[14:12] = 3'b010; x[6:0] = 7'b0000011;
        end else if (r < 62) begin
            x[14:12] = 3'b010; x[6:0] = 7'b0100011;
        end else if (r < 80) begin
            x[6:0] = 7'b1100011;
            if (r != 79) x[14:13] = 2'b00;
        end else if (r < 92) begin
            x[6:0] = 7'b1101111;
        end else if (r < 95) begin
            x = 32'h00000073;
        end else begin
            case ($urandom_range(0, 2))
                0: x[6:0] = 7'h7F;
                1: x[6:0] = 7'h37;
                default: x[6:0] = 7'h17;
            endcase
        end
        if (r < 52 || (r >= 80 && r < 92)) x[11:10] = 2'b00;
        return x;
    endfunction

    task automatic model_reset();
        m_k = 0; m_wait = 0; m_target = 0; m_stop = 0; m_inmem = 0;
        m_ir = 32'd0; m_pc = 8'd0; m_pcir = 8'd0;
        cyc = 0; mcount = 0;
    endtask

    task automatic drive();
        program_counter = m_pc;
        alu_zero = (zmode == 1) ? 1'b1 :
                   (zmode == 2) ? 1'b0 : 1'($urandom_range(0, 1));
        if (m_k == 3 && m_inmem && m_stop == 0)
            mem_ready = (m_wait + 1 == m_target);
        else
            mem_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic check_cycle();
        logic e_pc, e_be, e_we, e_req, e_mwe, e_h, e_t, tk;
        logic [1:0] e_ws;
        int kd;
        kd = kind_of(m_ir);
        tk = (m_ir[14:12] == 3'b000) ? alu_zero : !alu_zero;
        {e_pc, e_be, e_we, e_req, e_mwe, e_h, e_t} = '0;
        e_ws = 2'b00;
        if (m_stop == 1) e_h = 1'b1;
        else if (m_stop == 2) e_t = 1'b1;
        else if (m_k == 0) e_pc = 1'b1;
        else if (m_k == 2) begin
            e_be = (kd == K_JAL) || (kd == K_BR && tk);
            chk("alu_op", alu_op, aluop_of(m_ir));
            if (kd != K_JAL)
                chk("alu_src_imm", alu_src_imm,
                    kd == K_I || kd == K_LW || kd == K_SW);
        end else if (m_k == 3 && m_inmem) begin
            e_req = 1'b1;
            e_mwe = (kd == K_SW);
        end else if (m_k == 3) begin
            e_we = (m_ir[11:7] != 5'd0);
            e_ws = (kd == K_LW) ? 2'b01 : (kd == K_JAL) ? 2'b10 : 2'b00;
        end
        chk("pc_en", pc_en, e_pc);
        chk("bias_en", bias_en, e_be);
        chk("rf_we", rf_we, e_we);
        chk("mem_req", mem_req, e_req);
        chk("mem_we", mem_we, e_mwe);
        chk("wb_sel", wb_sel, e_ws);
        chk("halted", halted, e_h);
        chk("trap", trap, e_t);
        chk("imm", imm, imm_of(m_ir));
        chk("bias", bias, tgt_of(m_pcir, m_ir));
    endtask

    task automatic step();
        int kd, r;
        kd = kind_of(m_ir);
        if (m_stop != 0) return;
        if (m_k == 0) begin
            m_ir = prog[m_pc]; m_pcir = m_pc; m_pc = m_pc + 8'd1; m_k = 1;
        end else if (m_k == 1) begin
            if (kd == K_EC) m_stop = 1;
            else if (kd == K_ILL) m_stop = 2;
            else m_k = 2;
        end else if (m_k == 2) begin
            if (kd == K_BR) begin
                if ((m_ir[14:12] == 3'b000) ? alu_zero : !alu_zero)
                    m_pc = tgt_of(m_pcir, m_ir);
                m_k = 0;
            end else begin
                if (kd == K_JAL) m_pc = tgt_of(m_pcir, m_ir);
                m_k = 3;
                m_inmem = (kd == K_LW || kd == K_SW);
                m_wait = 0;
                r = $urandom_range(0, 9);
                if (tgt_fixed > 0) m_target = tgt_fixed;
                else m_target = (r == 0) ? 99 : (r == 1) ? 15 :
                                $urandom_range(1, 4);
            end
        end else if (m_inmem) begin
            if (mem_ready) begin
                m_inmem = 0;
                if (kd == K_SW) m_k = 0;
            end else begin
                m_wait++;
                if (m_wait == 15) m_stop = 2;
            end
        end else begin
            m_k = 0;
        end
    endtask

    task automatic lit_checks();
        case (scen)
            1: begin
                if (cyc == 0) chk("d1_pc_en_c0", pc_en, 1);
                if (cyc == 3) begin
                    chk("d1_addi_rf_we", rf_we, 1);
                    chk("d1_addi_wb_sel", wb_sel, 0);
                    chk("d1_addi_imm", imm, 5);
                end
                if (cyc == 4) chk("d1_refetch", pc_en, 1);
                if (cyc == 14) begin
                    chk("d1_beq_bias_en", bias_en, 1);
                    chk("d1_beq_bias", bias, 5);
                end
                if (cyc >= 15 && cyc <= 21 && mem_req) mcount++;
                if (cyc == 21) begin
                    chk("d1_lw_memreq_cycles", mcount, 3);
                    chk("d1_lw_wb_sel", wb_sel, 1);
                end
                if (cyc == 31) chk("d1_ecall_halted", halted, 1);
            end
            2: begin
                if (cyc == 14) chk("d2_bne_path_bias_en", bias_en, 0);
                if (cyc == 15) chk("d2_fallthrough_pc_en", pc_en, 1);
                if (cyc == 18) chk("d2_rd0_rf_we", rf_we, 0);
            end
            3: begin
                if (cyc == 10) chk("d3_jal_bias", bias, 254);
                if (cyc == 11) begin
                    chk("d3_jal_rf_we", rf_we, 1);
                    chk("d3_jal_wb_sel", wb_sel, 2);
                end
                if (cyc == 15) begin
                    chk("d3_illegal_trap", trap, 1);
                    chk("d3_no_pc_en", pc_en, 0);
                end
            end
            4: begin
                if (cyc == 17) chk("d4_last_mem_cycle", mem_req, 1);
                if (cyc == 18) begin
                    chk("d4_timeout_trap", trap, 1);
                    chk("d4_req_dropped", mem_req, 0);
                end
            end
            5: if (cyc == 2) chk("d5_bad_funct3_trap", trap, 1);
            default: ;
        endcase
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) begin
            drive();
            @(negedge clk);
            check_cycle();
            lit_checks();
            step();
            cyc++;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check_zero(input string nm);
        chk(nm, {pc_en, bias_en, bias, rf_we, alu_src_imm, alu_op, imm,
                 mem_req, mem_we, wb_sel, halted, trap}, 64'd0);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b0; mem_ready = 1'b0; alu_zero = 1'b0;
        program_counter = 8'd0;
        @(posedge clk);
        #1;
        check_zero("reset_outputs");
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic fill_ill();
        for (int i = 0; i < 256; i++) prog[i] = 32'h0000007F;
    endtask

    initial begin
        scen = 0; zmode = 0; tgt_fixed = 0;
        model_reset();
        fill_ill();

        chk("pin_imm_addi", imm_of(32'h00500093), 5);
        chk("pin_bias_beq", tgt_of(8'd3, 32'h00208463), 5);
        chk("pin_bias_jal", tgt_of(8'd2, 32'hFF1FF0EF), 254);
        chk("pin_kind_ecall", kind_of(32'h00000073), K_EC);

        fill_ill();
        for (int i = 0; i < 3; i++) prog[i] = 32'h00500093;
        prog[3] = 32'h00208463;
        prog[5] = 32'h00002283;
        prog[6] = 32'h00502023;
        prog[7] = 32'h00000073;
        scen = 1; zmode = 1; tgt_fixed = 3;
        do_reset();
        run(34);

        prog[4] = 32'h00500013;
        prog[5] = 32'h00000073;
        scen = 2; zmode = 2; tgt_fixed = 3;
        do_reset();
        run(24);

        fill_ill();
        prog[0] = 32'h00500093;
        prog[1] = 32'h00500093;
        prog[2] = 32'hFF1FF0EF;
        scen = 3; zmode = 0;
        do_reset();
        run(18);

        fill_ill();
        prog[0] = 32'h00002283;
        scen = 4; tgt_fixed = 99;
        do_reset();
        run(20);

        fill_ill();
        prog[0] = 32'h0020A463;
        scen = 5;
        do_reset();
        run(4);

        fill_ill();
        prog[0] = 32'h00002283;
        prog[1] = 32'h00000073;
        scen = 6; tgt_fixed = 99;
        do_reset();
        run(5);
        chk("d6_in_mem", mem_req, 1);
        rst_n = 1'b0;
        #1;
        chk("d6_async_memreq_drop", mem_req, 0);
        @(posedge clk);
        #1;
        check_zero("d6_reset_outputs");
        rst_n = 1'b1;
        model_reset();
        tgt_fixed = 1;
        run(8);

        for (int p = 0; p < 60; p++) begin
            for (int i = 0; i < 256; i++) prog[i] = rand_instr();
            scen = 0; zmode = 0; tgt_fixed = 0;
            do_reset();
            run(60);
        end

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
